// File: rtl/timer_sequencer.sv
// Millisecond timebase run-control: prescaler, sec/ms count and idle/run/pause/done sequencing.
// Supports count-up (stopwatch) and count-down (timer) modes with a saturating load preset.
module timer_sequencer #(
    parameter int CLK_PER_MS = 100000,
    parameter int SEC_W      = 14,
    parameter int MAX_SEC    = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load_en,
    input  logic [SEC_W-1:0] load_val,
    input  logic             mode,
    output logic [1:0]       state,
    output logic             ms_tick,
    output logic [9:0]       ms_cnt,
    output logic [SEC_W-1:0] sec_cnt,
    output logic             done,
    output logic             alarm
);

    localparam int               PSC_W    = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_PER_MS - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(MAX_SEC);
    localparam logic [9:0]       MS_LAST  = 10'd999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PSC_W-1:0] r_psc, w_psc_nxt;
    logic [9:0]       r_ms, w_ms_nxt;
    logic [SEC_W-1:0] r_sec, w_sec_nxt;
    logic             r_mode, w_mode_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_done, w_done_nxt;

    logic             w_wrap;
    logic             w_cnt_zero;
    logic             w_cnt_max;
    logic [9:0]       w_ms_step;
    logic [SEC_W-1:0] w_sec_step;
    logic             w_step_zero;
    logic [SEC_W-1:0] w_load_sat;

    assign w_wrap     = (r_psc == PSC_LAST);
    assign w_cnt_zero = (r_ms == 10'd0) && (r_sec == '0);
    assign w_cnt_max  = (r_ms == MS_LAST) && (r_sec == SEC_MAX);
    assign w_load_sat = (load_val > SEC_MAX) ? SEC_MAX : load_val;

    // One millisecond step in the latched direction, with carry/borrow into seconds.
    always_comb begin
        w_ms_step  = r_ms;
        w_sec_step = r_sec;
        if (!r_mode) begin
            if (r_ms == MS_LAST) begin
                w_ms_step  = 10'd0;
                w_sec_step = r_sec + SEC_W'(1);
            end else begin
                w_ms_step  = r_ms + 10'd1;
            end
        end else begin
            if (r_ms == 10'd0) begin
                w_ms_step  = MS_LAST;
                w_sec_step = r_sec - SEC_W'(1);
            end else begin
                w_ms_step  = r_ms - 10'd1;
            end
        end
    end

    assign w_step_zero = (w_ms_step == 10'd0) && (w_sec_step == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_psc_nxt   = r_psc;
        w_ms_nxt    = r_ms;
        w_sec_nxt   = r_sec;
        w_mode_nxt  = r_mode;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_ms_nxt  = 10'd0;
                    w_sec_nxt = '0;
                    w_psc_nxt = '0;
                end else begin
                    if (load_en) begin
                        w_sec_nxt = w_load_sat;
                        w_ms_nxt  = 10'd0;
                    end
                    // stop outranks start, so a simultaneous stop keeps us idle
                    if (start && !stop) begin
                        w_mode_nxt  = mode;
                        w_psc_nxt   = '0;
                        w_state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_ms_nxt    = 10'd0;
                    w_sec_nxt   = '0;
                    w_psc_nxt   = '0;
                end else if (stop) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_mode && w_cnt_zero) begin
                    // countdown started at 0.000: finish without a tick
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_psc_nxt = w_wrap ? '0 : r_psc + PSC_W'(1);
                    if (w_wrap) begin
                        if (!r_mode && w_cnt_max) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_ms_nxt   = w_ms_step;
                            w_sec_nxt  = w_sec_step;
                            w_tick_nxt = 1'b1;
                            if (r_mode && w_step_zero) begin
                                w_state_nxt = S_DONE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end
                end
            end

            S_PAUSE: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_ms_nxt    = 10'd0;
                    w_sec_nxt   = '0;
                    w_psc_nxt   = '0;
                end else if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_DONE: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_ms_nxt    = 10'd0;
                    w_sec_nxt   = '0;
                    w_psc_nxt   = '0;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_psc   <= '0;
            r_ms    <= 10'd0;
            r_sec   <= '0;
            r_mode  <= 1'b0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_psc   <= w_psc_nxt;
            r_ms    <= w_ms_nxt;
            r_sec   <= w_sec_nxt;
            r_mode  <= w_mode_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign state   = r_state;
    assign ms_tick = r_tick;
    assign ms_cnt  = r_ms;
    assign sec_cnt = r_sec;
    assign done    = r_done;
    assign alarm   = (r_state == S_DONE);

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: two instances share stimulus, one with a tiny seconds limit.
module tb_timer_sequencer;

    localparam int CPM = 4;

    logic        clk = 1'b0;
    logic        rst, start, stop, clear, load_en, mode;
    logic [14:0] load_val;

    logic [1:0]  state, state_b;
    logic        ms_tick, ms_tick_b, done, done_b, alarm, alarm_b;
    logic [9:0]  ms_cnt, ms_cnt_b;
    logic [14:0] sec_cnt;
    logic [13:0] sec_cnt_b;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timer_sequencer #(.CLK_PER_MS(CPM), .SEC_W(15), .MAX_SEC(9999)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load_en(load_en), .load_val(load_val), .mode(mode),
        .state(state), .ms_tick(ms_tick), .ms_cnt(ms_cnt), .sec_cnt(sec_cnt),
        .done(done), .alarm(alarm)
    );

    timer_sequencer #(.CLK_PER_MS(CPM), .SEC_W(14), .MAX_SEC(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .load_en(load_en), .load_val(load_val[13:0]), .mode(mode),
        .state(state_b), .ms_tick(ms_tick_b), .ms_cnt(ms_cnt_b), .sec_cnt(sec_cnt_b),
        .done(done_b), .alarm(alarm_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load_en = 1'b0; mode = 1'b0; load_val = '0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_ms", ms_cnt, 0);
        chk("rst_sec", sec_cnt, 0);
        chk("rst_tick", ms_tick, 0);
        chk("rst_done", done, 0);
        chk("rst_alarm", alarm, 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);

        // count up: ticks every CPM cycles after start
        start = 1'b1; mode = 1'b0;
        cyc(1);
        start = 1'b0;
        chk("up_run", state, 1);
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            chk($sformatf("up_tick_e%0d", k), ms_tick, (k % CPM == 0) ? 1 : 0);
        end
        chk("up_ms3", ms_cnt, 3);
        chk("up_sec0", sec_cnt, 0);

        // stop on the tick edge drops the tick; resume ticks one edge later
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stp_state", state, 2);
        chk("stp_tick", ms_tick, 0);
        chk("stp_ms", ms_cnt, 3);
        cyc(3);
        chk("pause_hold_ms", ms_cnt, 3);
        chk("pause_hold_tick", ms_tick, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("res_state", state, 1);
        chk("res_tick_r", ms_tick, 0);
        cyc(1);
        chk("res_tick_r1", ms_tick, 1);
        chk("res_ms", ms_cnt, 4);

        // load ignored while running
        load_en = 1'b1; load_val = 15'd20000;
        cyc(1);
        load_en = 1'b0;
        chk("run_load_sec", sec_cnt, 0);
        chk("run_load_state", state, 1);

        // clear+start in pause: clear wins
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("pause2_state", state, 2);
        clear = 1'b1; start = 1'b1;
        cyc(1);
        clear = 1'b0; start = 1'b0;
        chk("clr_state", state, 0);
        chk("clr_ms", ms_cnt, 0);
        chk("clr_sec", sec_cnt, 0);

        // saturating load in idle
        load_en = 1'b1; load_val = 15'd20000;
        cyc(1);
        load_en = 1'b0;
        chk("load_sat_sec", sec_cnt, 9999);
        chk("load_sat_ms", ms_cnt, 0);
        chk("load_sat_b", sec_cnt_b, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("idle_clr_sec", sec_cnt, 0);

        // countdown from 1.000 with load+start together
        load_en = 1'b1; load_val = 15'd1; start = 1'b1; mode = 1'b1;
        cyc(1);
        load_en = 1'b0; start = 1'b0; mode = 1'b0;
        chk("dn_state", state, 1);
        chk("dn_sec", sec_cnt, 1);
        chk("dn_ms", ms_cnt, 0);
        cyc(3996);
        chk("dn_999_ms", ms_cnt, 1);
        chk("dn_999_sec", sec_cnt, 0);
        chk("dn_999_state", state, 1);
        cyc(4);
        chk("dn_end_state", state, 3);
        chk("dn_end_ms", ms_cnt, 0);
        chk("dn_end_sec", sec_cnt, 0);
        chk("dn_end_done", done, 1);
        chk("dn_end_alarm", alarm, 1);
        chk("dn_end_tick", ms_tick, 1);
        start = 1'b1; stop = 1'b1; load_en = 1'b1; load_val = 15'd5;
        cyc(1);
        start = 1'b0; stop = 1'b0; load_en = 1'b0;
        chk("done_pulse", done, 0);
        chk("done_hold_state", state, 3);
        chk("done_hold_alarm", alarm, 1);
        chk("done_hold_sec", sec_cnt, 0);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("done_clr_state", state, 0);
        chk("done_clr_alarm", alarm, 0);

        // countdown from 0.000 finishes on the next edge without a tick
        start = 1'b1; mode = 1'b1;
        cyc(1);
        start = 1'b0; mode = 1'b0;
        chk("dz_run", state, 1);
        cyc(1);
        chk("dz_state", state, 3);
        chk("dz_done", done, 1);
        chk("dz_tick", ms_tick, 0);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;

        // count up to the seconds limit on the MAX_SEC=1 instance
        start = 1'b1; mode = 1'b0;
        cyc(1);
        start = 1'b0;
        cyc(7996);
        chk("max_pre_ms", ms_cnt_b, 999);
        chk("max_pre_sec", sec_cnt_b, 1);
        chk("max_pre_state", state_b, 1);
        cyc(4);
        chk("max_state", state_b, 3);
        chk("max_ms", ms_cnt_b, 999);
        chk("max_sec", sec_cnt_b, 1);
        chk("max_done", done_b, 1);
        chk("max_alarm", alarm_b, 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;

        // async reset mid-run
        start = 1'b1; mode = 1'b0;
        cyc(1);
        start = 1'b0;
        cyc(2068);
        chk("pre_rst_ms", ms_cnt, 517);
        chk("pre_rst_sec", sec_cnt, 0);
        cyc(2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_ms", ms_cnt, 0);
        chk("arst_sec", sec_cnt, 0);
        chk("arst_tick", ms_tick, 0);
        chk("arst_done", done, 0);
        chk("arst_alarm", alarm, 0);
        cyc(5);
        chk("arst_hold_tick", ms_tick, 0);
        chk("arst_hold_state", state, 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
